// File: rtl/mem_bus_pkg.sv
// Shared mem_bus definitions: arbiter states,
// num_bytes encodings and requester port indices.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  localparam logic [2:0] NB_1 = 3'd1;
  localparam logic [2:0] NB_2 = 3'd2;
  localparam logic [2:0] NB_4 = 3'd4;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/mem_watchdog.sv
// Busy-cycle watchdog: counts enabled cycles and
// flags the cycle on which the count reaches all-ones.
module mem_watchdog #(
  parameter int W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] ONE  = 1;
  localparam logic [W-1:0] LAST = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && cnt != '1) begin
      cnt <= cnt + ONE;
    end
  end

  // the 2^W-1th enabled cycle is the expiry cycle
  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter in front of mem_bus: CPU (0)
// and debug loader (1), with a busy watchdog.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W    = 18,
  parameter int TIMEOUT_W = 16,
  parameter bit FAIR      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [2:0]        nb0,
  input  logic [2:0]        nb1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              done0,
  output logic              done1,
  output logic [31:0]       rdata,
  output logic              err0,
  output logic              err1,
  output logic              m_start,
  output logic              m_write,
  output logic [2:0]        m_nb,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic              m_done,
  input  logic [31:0]       m_rdata,
  output logic              busy
);

  arb_state_t state;
  logic       grant;
  logic       last;
  logic       pick;
  logic       req_g;
  logic       live;
  logic       wd_en;
  logic       wd_clr;
  logic       wd_exp;
  logic [1:0] done_q;
  logic [1:0] err_q;

  assign req_g  = grant ? req1 : req0;
  assign live   = (state != ST_IDLE);
  assign wd_en  = (state == ST_BUSY);
  assign wd_clr = (state == ST_RELEASE)
                && !req_g && !m_done;

  always_comb begin
    pick = PORT_CPU;
    unique case (1'b1)
      req0 && req1: pick = FAIR ? ~last : PORT_DBG;
      req1 && !req0: pick = PORT_DBG;
      default: pick = PORT_CPU;
    endcase
  end

  mem_watchdog #(
    .W(TIMEOUT_W)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant   <= PORT_CPU;
      last    <= PORT_DBG;
      m_start <= 1'b0;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            grant   <= pick;
            m_start <= 1'b1;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // a real m_done beats a same-cycle expiry
          if (m_done || wd_exp) begin
            m_start       <= 1'b0;
            done_q[grant] <= 1'b1;
            err_q[grant]  <= !m_done;
            state         <= ST_RELEASE;
          end else begin
            m_start <= req_g;
          end
        end
        ST_RELEASE: begin
          if (wd_clr) begin
            done_q <= 2'b00;
            err_q  <= 2'b00;
            last   <= grant;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign done0 = done_q[0];
  assign done1 = done_q[1];
  assign err0  = err_q[0];
  assign err1  = err_q[1];
  assign busy  = live;
  assign rdata = m_rdata;

  assign m_write = live && (grant ? wr1 : wr0);
  assign m_nb    = live ? (grant ? nb1 : nb0) : '0;
  assign m_addr  = live ? (grant ? addr1 : addr0) : '0;
  assign m_wdata = live ? (grant ? wdata1 : wdata0) : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Random traffic on three arbiter configurations,
// checked against a transaction-level reference model.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int NI = 3;
  localparam int NCYC = 8000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rq  [NI][2];
  logic        wr  [NI][2];
  logic [2:0]  nbv [NI][2];
  logic [17:0] ad  [NI][2];
  logic [31:0] wdv [NI][2];
  logic        dn  [NI][2];
  logic        er  [NI][2];
  logic [31:0] rd_o [NI];
  logic        ms_o [NI];
  logic        mw_o [NI];
  logic [2:0]  mnb_o [NI];
  logic [17:0] ma_o [NI];
  logic [31:0] mwd_o [NI];
  logic        busy_o [NI];
  logic        md  [NI];
  logic [31:0] mrd [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    mem_bus_arbiter #(
      .ADDR_W    (18),
      .TIMEOUT_W (k == 2 ? 16 : 4),
      .FAIR      (k != 1)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .req0    (rq[k][0]),
      .req1    (rq[k][1]),
      .wr0     (wr[k][0]),
      .wr1     (wr[k][1]),
      .nb0     (nbv[k][0]),
      .nb1     (nbv[k][1]),
      .addr0   (ad[k][0]),
      .addr1   (ad[k][1]),
      .wdata0  (wdv[k][0]),
      .wdata1  (wdv[k][1]),
      .done0   (dn[k][0]),
      .done1   (dn[k][1]),
      .rdata   (rd_o[k]),
      .err0    (er[k][0]),
      .err1    (er[k][1]),
      .m_start (ms_o[k]),
      .m_write (mw_o[k]),
      .m_nb    (mnb_o[k]),
      .m_addr  (ma_o[k]),
      .m_wdata (mwd_o[k]),
      .m_done  (md[k]),
      .m_rdata (mrd[k]),
      .busy    (busy_o[k])
    );
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // reference model: who owns the bus and for how long
  int tmax  [NI] = '{15, 15, 65535};
  bit fairp [NI] = '{1'b1, 1'b0, 1'b1};
  int own   [NI];
  int phase [NI];
  int bcyc  [NI];
  int lastp [NI];
  bit aborted [NI];
  bit start_x [NI];

  // stimulus state
  int rdrop [NI][2];
  bit mact  [NI];
  int mcnt  [NI];
  int mlat  [NI];
  int mhold [NI];

  function automatic int new_lat();
    if ($urandom_range(0, 9) == 0)
      return $urandom_range(14, 45);
    return $urandom_range(1, 6);
  endfunction

  task automatic compare(input int k);
    string t;
    bit    inb;
    int    o;
    t   = $sformatf("u%0d", k);
    inb = (phase[k] == 1);
    o   = own[k];
    check({t, ".busy"}, 64'(busy_o[k]),
          64'(phase[k] != 0));
    check({t, ".m_start"}, 64'(ms_o[k]),
          64'(start_x[k]));
    for (int p = 0; p < 2; p++) begin
      check($sformatf("%s.done%0d", t, p),
            64'(dn[k][p]),
            64'(phase[k] == 2 && o == p));
      check($sformatf("%s.err%0d", t, p),
            64'(er[k][p]),
            64'(phase[k] == 2 && o == p && aborted[k]));
    end
    check({t, ".rdata"}, 64'(rd_o[k]), 64'(mrd[k]));
    if (phase[k] == 0) begin
      check({t, ".idle_addr"}, 64'(ma_o[k]), 64'(0));
      check({t, ".idle_wr"}, 64'(mw_o[k]), 64'(0));
    end
    if (inb) begin
      check({t, ".m_write"}, 64'(mw_o[k]),
            64'(wr[k][o]));
      check({t, ".m_nb"}, 64'(mnb_o[k]),
            64'(nbv[k][o]));
      check({t, ".m_addr"}, 64'(ma_o[k]),
            64'(ad[k][o]));
      check({t, ".m_wdata"}, 64'(mwd_o[k]),
            64'(wdv[k][o]));
    end
  endtask

  task automatic drive_req(input int k);
    int s;
    for (int p = 0; p < 2; p++) begin
      if (rst) begin
        rq[k][p] = 1'b0;
        rdrop[k][p] = -1;
      end else if (!rq[k][p]) begin
        if ($urandom_range(0, 3) == 0) begin
          s = $urandom_range(0, 2);
          rq[k][p]  = 1'b1;
          wr[k][p]  = 1'($urandom);
          nbv[k][p] = (s == 0) ? NB_1 :
                      (s == 1) ? NB_2 : NB_4;
          ad[k][p]  = 18'($urandom);
          wdv[k][p] = $urandom;
        end
      end else begin
        if (dn[k][p] && rdrop[k][p] < 0)
          rdrop[k][p] = $urandom_range(0, 2);
        if (rdrop[k][p] == 0) begin
          rq[k][p] = 1'b0;
          rdrop[k][p] = -1;
        end else if (rdrop[k][p] > 0) begin
          rdrop[k][p]--;
        end else if ($urandom_range(0, 199) == 0) begin
          rq[k][p] = 1'b0;
        end
      end
    end
  endtask

  task automatic drive_mem(input int k);
    mrd[k] = $urandom;
    if (rst) begin
      md[k] = 1'b0;
      mact[k] = 1'b0;
    end else if (md[k]) begin
      if (!ms_o[k]) begin
        if (mhold[k] > 0) mhold[k]--;
        else md[k] = 1'b0;
      end
    end else if (mact[k]) begin
      if (!busy_o[k]) begin
        mact[k] = 1'b0;
      end else begin
        mcnt[k]++;
        if (mcnt[k] >= mlat[k]) begin
          md[k] = 1'b1;
          mact[k] = 1'b0;
          mhold[k] = $urandom_range(0, 3);
        end
      end
    end else if (ms_o[k] && busy_o[k]) begin
      mact[k] = 1'b1;
      mcnt[k] = 0;
      mlat[k] = new_lat();
    end
  endtask

  task automatic model_step(input int k);
    bit a;
    bit b;
    if (rst) begin
      phase[k] = 0;
      own[k] = 0;
      lastp[k] = 1;
      bcyc[k] = 0;
      aborted[k] = 1'b0;
      start_x[k] = 1'b0;
      return;
    end
    a = rq[k][0];
    b = rq[k][1];
    case (phase[k])
      0: if (a || b) begin
        if (a && b) own[k] = fairp[k] ? 1 - lastp[k] : 1;
        else own[k] = b ? 1 : 0;
        phase[k] = 1;
        bcyc[k] = 0;
        start_x[k] = 1'b1;
      end
      1: begin
        bcyc[k]++;
        if (md[k]) begin
          phase[k] = 2;
          aborted[k] = 1'b0;
          start_x[k] = 1'b0;
        end else if (bcyc[k] == tmax[k]) begin
          phase[k] = 2;
          aborted[k] = 1'b1;
          start_x[k] = 1'b0;
        end else begin
          start_x[k] = rq[k][own[k]];
        end
      end
      default: if (!rq[k][own[k]] && !md[k]) begin
        phase[k] = 0;
        lastp[k] = own[k];
        aborted[k] = 1'b0;
      end
    endcase
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      md[k] = 1'b0;
      mrd[k] = '0;
      mact[k] = 1'b0;
      mcnt[k] = 0;
      mlat[k] = 1;
      mhold[k] = 0;
      phase[k] = 0;
      own[k] = 0;
      lastp[k] = 1;
      bcyc[k] = 0;
      aborted[k] = 1'b0;
      start_x[k] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        rq[k][p] = 1'b0;
        wr[k][p] = 1'b0;
        nbv[k][p] = '0;
        ad[k][p] = '0;
        wdv[k][p] = '0;
        rdrop[k][p] = -1;
      end
    end
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc > 0)
        for (int k = 0; k < NI; k++) compare(k);
      rst = (cyc < 3) || ($urandom_range(0, 399) == 0);
      for (int k = 0; k < NI; k++) begin
        drive_req(k);
        drive_mem(k);
        model_step(k);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single mem_bus transaction port between two requesters: port 0 is the CPU core (instruction fetch and load/store), port 1 is the debug/program loader (writes RAM, peeks registers mapped in memory).
- It sits between the requesters and mem_bus. It forwards one requester's command fields and its start/done level handshake at a time.
- A watchdog aborts a transaction that never completes.

Parameters:
- ADDR_W, 18, width of target_address (16 address bits + 2 chip-select/space bits).
- TIMEOUT_W, 16, width of the watchdog counter; abort after 2^TIMEOUT_W-1 busy cycles.
- FAIR, 1, 1 = round-robin between ports; 0 = fixed priority, port 1 wins.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req0/req1  in  1  port start_request level; held high until the port's done is seen.
- wr0/wr1  in  1  is_write for the port.
- nb0/nb1  in  3  num_bytes (1, 2 or 4).
- addr0/addr1  in  ADDR_W  target address.
- wdata0/wdata1  in  32  write value.
- done0/done1  out  1  request_done returned to the port.
- rdata  out  32  fetched_value, shared by both ports; valid while doneX=1.
- err0/err1  out  1  high together with doneX when the transaction was aborted by timeout.
- m_start  out  1  start_request to mem_bus.
- m_write, m_nb, m_addr, m_wdata  out  1/3/ADDR_W/32  command to mem_bus, muxed from the granted port.
- m_done  in  1  request_done from mem_bus.
- m_rdata  in  32  fetched_value from mem_bus.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE; m_start, done0, done1, err0, err1, busy = 0; grant=0; last=1, so port 0 wins the first tie; watchdog=0. Command outputs are 0 while in IDLE.
- States:
  - IDLE: if any reqX, latch grant, set m_start=1 next cycle, go to BUSY. Arbitration uses the registered req only, so grant-to-m_start latency is 1 cycle.
  - Tie (both req in the same cycle):
    - FAIR=1: grant the port that is not `last`.
    - FAIR=0: grant port 1.
  - BUSY: m_start=1; m_* fields track the granted port combinationally. The requester must hold its fields stable, so the arbiter does not latch them.
    - On m_done=1: drop m_start, set doneX=1, go to RELEASE.
    - Watchdog increments every BUSY cycle. On reaching all-ones with m_done=0: drop m_start, set doneX=1 and errX=1, go to RELEASE.
  - RELEASE: doneX (and errX) stay high until reqX=0 and m_done=0. Then clear doneX/errX, set last=grant, clear the watchdog, and return to IDLE.
    - No new grant is issued in the same cycle as the return to IDLE.
    - So back-to-back transactions have at least 1 idle cycle.
- Granted port drops req before done (abort by requester):
  - m_start drops the next cycle.
  - The arbiter still waits in BUSY for m_done or timeout, then enters RELEASE.
  - doneX is asserted and then cleared at once, because req is already 0.
- The ungranted port's done and err stay 0. Its req is ignored until IDLE and it is never dropped.
- With FAIR=1, a port waits at most one transaction.
- Reset mid-transaction: everything returns to reset values the next cycle and m_start drops. mem_bus is reset by the same rst, so no cleanup is needed.
- rdata = m_rdata, passed through unregistered.

Decomposition:
- Shared package (mem_bus_pkg): arbiter state encoding (IDLE, BUSY, RELEASE), the num_bytes encodings (NB_1=1, NB_2=2, NB_4=4) and the port index constants. mem_bus uses the same package.
- One sub-module: mem_watchdog (counter with clear/enable and expired output). It is reusable by the UART and io blocks.

Test Plan:
- Single port-0 read: req0, addr0=0x00010, nb0=4; m_done asserted 40 cycles later with m_rdata=0xDEADBEEF -> m_start high 1 cycle after req0; done0=1, rdata=0xDEADBEEF; after req0 drops, busy returns to 0.
- Simultaneous req0/req1 with FAIR=1, then repeated: grants alternate 0,1,0,1. With FAIR=0, port 1 always wins and port 0 is served only when req1=0.
- Write pass-through on port 1: wr1=1, addr1=0x20004, wdata1=0x12345678, nb1=2 -> m_write=1, m_addr=0x20004, m_wdata=0x12345678, m_nb=2 while BUSY.
- Timeout with TIMEOUT_W=4 and m_done stuck at 0 -> after 15 BUSY cycles: m_start=0, done0=err0=1; IDLE only after req0=0.
- m_done held high late: requester drops req but m_done remains 1 for 3 more cycles -> arbiter stays in RELEASE and a pending req1 is not granted until m_done=0.
- rst asserted in BUSY -> next cycle m_start=0, done*=0, busy=0; a req1 made after reset release is granted normally.
